// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H cycles high separated by L cycles low,
// launched through a valid/ready handshake, with registered edge strobes and done flag.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_low,
   input  logic [NUM_W-1:0] cfg_num,
   input  logic             abort,
   output logic             pulse_out,
   output logic             rise_strobe,
   output logic             fall_strobe,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] h_m1, h_m1_nxt;
   logic [CNT_W-1:0] l_m1, l_m1_nxt;
   logic [NUM_W-1:0] rem, rem_nxt;
   logic             pulse_nxt, rise_nxt, fall_nxt, done_nxt;
   logic             accept;

   assign start_ready = (state == IDLE) & ~abort & ~reset;
   assign accept      = start_valid & start_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         h_m1        <= '0;
         l_m1        <= '0;
         rem         <= '0;
         pulse_out   <= 1'b0;
         rise_strobe <= 1'b0;
         fall_strobe <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         h_m1        <= h_m1_nxt;
         l_m1        <= l_m1_nxt;
         rem         <= rem_nxt;
         pulse_out   <= pulse_nxt;
         rise_strobe <= rise_nxt;
         fall_strobe <= fall_nxt;
         done        <= done_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

   // Phase counters hold "cycles remaining minus one", so a field of 0 or 1 both give one
   // cycle and the max field value never needs a wider counter.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      h_m1_nxt  = h_m1;
      l_m1_nxt  = l_m1;
      rem_nxt   = rem;
      pulse_nxt = pulse_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               h_m1_nxt = (cfg_high == '0) ? '0 : cfg_high - CNT_W'(1);
               l_m1_nxt = (cfg_low == '0) ? '0 : cfg_low - CNT_W'(1);
               rem_nxt  = cfg_num;
               if (cfg_num == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = HIGH;
                  pulse_nxt = 1'b1;
                  rise_nxt  = 1'b1;
                  cnt_nxt   = h_m1_nxt;
               end
            end
         end
         HIGH: begin
            if (abort) begin
               state_nxt = IDLE;
               pulse_nxt = 1'b0;
               fall_nxt  = pulse_out;
            end else if (cnt == '0) begin
               pulse_nxt = 1'b0;
               fall_nxt  = 1'b1;
               rem_nxt   = rem - NUM_W'(1);
               if (rem == NUM_W'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = LOW;
                  cnt_nxt   = l_m1;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         LOW: begin
            if (abort) begin
               state_nxt = IDLE;
               pulse_nxt = 1'b0;
               fall_nxt  = pulse_out;
            end else if (cnt == '0) begin
               state_nxt = HIGH;
               pulse_nxt = 1'b1;
               rise_nxt  = 1'b1;
               cnt_nxt   = h_m1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            pulse_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen; cycle k=1 is the cycle after accept.
module tb_pulse_train_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_valid;
   logic       start_ready;
   logic [7:0] cfg_high;
   logic [7:0] cfg_low;
   logic [7:0] cfg_num;
   logic       abort;
   logic       pulse_out;
   logic       rise_strobe;
   logic       fall_strobe;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
      .cfg_num     (cfg_num),
      .abort       (abort),
      .pulse_out   (pulse_out),
      .rise_strobe (rise_strobe),
      .fall_strobe (fall_strobe),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
      cfg_high    = h;
      cfg_low     = l;
      cfg_num     = n;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      reset = 1'b1; start_valid = 1'b0; abort = 1'b0;
      cfg_high = '0; cfg_low = '0; cfg_num = '0;
      tick();
      tick();
      obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
      checks++;
      if (obs !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b0);
      end
      checks++;
      if (start_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_reset got=%b exp=0", start_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (start_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got=%b exp=1", start_ready);
      end
   endtask

   task automatic test_basic();
      logic [4:0] obs, exp;
      request(8'd2, 8'd3, 8'd3);
      for (int k = 1; k <= 14; k++) begin
         exp[4] = (k == 1 || k == 2 || k == 6 || k == 7 || k == 11 || k == 12);
         exp[3] = (k == 1 || k == 6 || k == 11);
         exp[2] = (k == 3 || k == 8 || k == 13);
         exp[1] = (k == 13);
         exp[0] = (k >= 1 && k <= 12);
         obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL basic k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_zero_fields();
      logic [4:0] obs, exp;
      request(8'd0, 8'd0, 8'd2);
      for (int k = 1; k <= 5; k++) begin
         exp[4] = (k == 1 || k == 3);
         exp[3] = (k == 1 || k == 3);
         exp[2] = (k == 2 || k == 4);
         exp[1] = (k == 4);
         exp[0] = (k <= 3);
         obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL zero_hl k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick();
      end
      request(8'd4, 8'd4, 8'd0);
      for (int k = 1; k <= 2; k++) begin
         exp = (k == 1) ? 5'b00010 : 5'b00000;
         obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL zero_num k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      logic [4:0] obs;
      int         bad;
      request(8'd5, 8'd1, 8'd4);
      // k=1..5 high, k=6 low, second high starts at k=7; abort sampled at end of k=8
      for (int k = 1; k < 8; k++) tick();
      checks++;
      if (pulse_out !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre got=%b exp=1", pulse_out);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
      checks++;
      if (obs !== 5'b00100) begin
         failures++;
         $display("FAIL abort_next got=%b exp=%b", obs, 5'b00100);
      end
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (done !== 1'b0 || pulse_out !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL abort_quiet bad_cycles=%0d exp=0", bad);
      end
      cfg_high = 8'd2; cfg_low = 8'd2; cfg_num = 8'd1;
      start_valid = 1'b1;
      abort = 1'b1;
      #1;
      checks++;
      if (start_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_ready got=%b exp=0", start_ready);
      end
      tick();
      start_valid = 1'b0;
      abort = 1'b0;
      obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
      checks++;
      if (obs !== 5'b0) begin
         failures++;
         $display("FAIL abort_idle_accept got=%b exp=%b", obs, 5'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] obs, exp;
      request(8'd1, 8'd1, 8'd2);
      // cfg changes mid-train must be ignored by the running train
      cfg_high = 8'd7; cfg_low = 8'd9; cfg_num = 8'd9;
      for (int k = 1; k <= 4; k++) begin
         exp[4] = (k == 1 || k == 3);
         exp[3] = (k == 1 || k == 3);
         exp[2] = (k == 2 || k == 4);
         exp[1] = (k == 4);
         exp[0] = (k <= 3);
         obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_first k=%0d got=%b exp=%b", k, obs, exp);
         end
         if (k < 4) tick();
      end
      checks++;
      if (start_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready_in_done got=%b exp=1", start_ready);
      end
      request(8'd3, 8'd2, 8'd1);
      cfg_high = 8'd1; cfg_num = 8'd5;
      for (int k = 1; k <= 5; k++) begin
         exp[4] = (k <= 3);
         exp[3] = (k == 1);
         exp[2] = (k == 4);
         exp[1] = (k == 4);
         exp[0] = (k <= 3);
         obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_second k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_train();
      logic [4:0] obs;
      request(8'd4, 8'd2, 8'd2);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      obs = {pulse_out, rise_strobe, fall_strobe, done, busy};
      checks++;
      if (obs !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid got=%b exp=%b", obs, 5'b0);
      end
   endtask

   task automatic test_edge_cross();
      logic prev;
      int   bad;
      prev = pulse_out;
      bad  = 0;
      request(8'd2, 8'd1, 8'd3);
      for (int k = 1; k <= 12; k++) begin
         if (rise_strobe !== (pulse_out & ~prev) || fall_strobe !== (~pulse_out & prev)) bad++;
         if (rise_strobe === 1'b1 && fall_strobe === 1'b1) bad++;
         prev = pulse_out;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL edge_cross bad_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_max_width();
      int highs;
      int fall_k;
      highs  = 0;
      fall_k = -1;
      request(8'd255, 8'd1, 8'd1);
      for (int k = 1; k <= 300; k++) begin
         if (pulse_out === 1'b1) highs++;
         if (fall_strobe === 1'b1 && fall_k < 0) fall_k = k;
         tick();
      end
      checks++;
      if (highs !== 255) begin
         failures++;
         $display("FAIL max_high_cycles got=%0d exp=255", highs);
      end
      checks++;
      if (fall_k !== 256) begin
         failures++;
         $display("FAIL max_fall_cycle got=%0d exp=256", fall_k);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_fields();
      test_abort();
      test_back_to_back();
      test_reset_mid_train();
      test_edge_cross();
      test_max_width();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
